// File: rtl/interrupt_sequencer_pkg.sv
// Shared definitions for the interrupt sequencer: INTCON bit positions and
// sequencer state encodings.
package interrupt_sequencer_pkg;

    localparam int INTCON_GIE  = 7;
    localparam int INTCON_PEIE = 6;
    localparam int INTCON_T0IE = 5;
    localparam int INTCON_INTE = 4;
    localparam int INTCON_RBIE = 3;
    localparam int INTCON_T0IF = 2;
    localparam int INTCON_INTF = 1;
    localparam int INTCON_RBIF = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_VECTOR = 2'd2,
        ST_SLEEP  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Core-side bundle of the interrupt sequencer: INTCON/PIR1/PIE1 view, instruction
// events and the PC/stack/flush controls it drives back into the core.
interface interrupt_sequencer_if #(
    parameter int PC_WIDTH = 13
);
    logic                instr_boundary;
    logic [7:0]          intcon;
    logic [7:0]          pir1;
    logic [7:0]          pie1;
    logic [PC_WIDTH-1:0] pc_in;
    logic                retfie_exec;
    logic                sleep_exec;

    logic                core_stall;
    logic                instr_flush_req;
    logic                stack_push;
    logic [PC_WIDTH-1:0] stack_push_data;
    logic                pc_vector_en;
    logic [PC_WIDTH-1:0] pc_vector_addr;
    logic                gie_clr;
    logic                gie_set;
    logic                in_isr;
    logic                asleep;

    modport master (
        output instr_boundary, intcon, pir1, pie1, pc_in, retfie_exec, sleep_exec,
        input  core_stall, instr_flush_req, stack_push, stack_push_data,
               pc_vector_en, pc_vector_addr, gie_clr, gie_set, in_isr, asleep
    );

    modport slave (
        input  instr_boundary, intcon, pir1, pie1, pc_in, retfie_exec, sleep_exec,
        output core_stall, instr_flush_req, stack_push, stack_push_data,
               pc_vector_en, pc_vector_addr, gie_clr, gie_set, in_isr, asleep
    );

endinterface

// File: rtl/interrupt_sequencer_irq_pending_logic.sv
// Combinational interrupt request terms: pend ignores GIE (used for SLEEP wake),
// irq is pend qualified by GIE.
module interrupt_sequencer_irq_pending_logic
    import interrupt_sequencer_pkg::*;
(
    input  logic [7:0] i_intcon,
    input  logic [7:0] i_pir1,
    input  logic [7:0] i_pie1,
    output logic       o_pend,
    output logic       o_irq
);

    logic w_periph;

    assign w_periph = |(i_pir1 & i_pie1);

    assign o_pend = (i_intcon[INTCON_T0IE] & i_intcon[INTCON_T0IF])
                  | (i_intcon[INTCON_INTE] & i_intcon[INTCON_INTF])
                  | (i_intcon[INTCON_RBIE] & i_intcon[INTCON_RBIF])
                  | (i_intcon[INTCON_PEIE] & w_periph);

    assign o_irq = i_intcon[INTCON_GIE] & o_pend;

endmodule

// File: rtl/interrupt_sequencer.sv
// Interrupt entry and SLEEP wake-up sequencer: injects a forced-NOP slot and a
// vectoring slot at an instruction boundary when an enabled interrupt is pending.
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
#(
    parameter int                  PC_WIDTH    = 13,
    parameter logic [PC_WIDTH-1:0] VECTOR_ADDR = 13'h0004,
    parameter int                  SLOT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    interrupt_sequencer_if.slave bus
);

    localparam int              PH_W    = $clog2(SLOT_CYCLES);
    localparam logic [PH_W-1:0] PH_ZERO = {PH_W{1'b0}};
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOT_CYCLES - 1);

    seq_state_t          r_state;
    seq_state_t          w_state_nxt;
    logic [PH_W-1:0]     r_ph;
    logic [PH_W-1:0]     w_ph_nxt;
    logic [PC_WIDTH-1:0] r_push_data;
    logic                w_latch_pc;
    logic                r_in_isr;
    logic                w_in_isr_nxt;
    logic                r_core_stall;
    logic                r_flush;
    logic                r_push;
    logic                r_vector;
    logic                r_asleep;
    logic                w_pend;
    logic                w_irq;
    logic                w_gie;

    interrupt_sequencer_irq_pending_logic u_pending (
        .i_intcon (bus.intcon),
        .i_pir1   (bus.pir1),
        .i_pie1   (bus.pie1),
        .o_pend   (w_pend),
        .o_irq    (w_irq)
    );

    assign w_gie = bus.intcon[INTCON_GIE];

    // Next-state, slot counter, return-address capture and in_isr tracking
    always_comb begin
        w_state_nxt = r_state;
        w_ph_nxt    = r_ph + PH_ONE;
        w_latch_pc  = 1'b0;
        if (bus.retfie_exec && (r_state != ST_SLEEP)) begin
            w_in_isr_nxt = 1'b0;
        end else begin
            w_in_isr_nxt = r_in_isr;
        end
        case (r_state)
            ST_IDLE: begin
                w_ph_nxt = PH_ZERO;
                // GIE is sampled before any same-cycle RETFIE set takes effect
                if (bus.instr_boundary && w_irq) begin
                    w_latch_pc  = 1'b1;
                    w_state_nxt = ST_FLUSH;
                end else if (bus.sleep_exec) begin
                    w_state_nxt = ST_SLEEP;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (r_ph == PH_LAST) begin
                    w_state_nxt = ST_VECTOR;
                    w_ph_nxt    = PH_ZERO;
                end else begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_VECTOR: begin
                if (r_ph == PH_LAST) begin
                    w_state_nxt  = ST_IDLE;
                    w_ph_nxt     = PH_ZERO;
                    w_in_isr_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_VECTOR;
                end
            end
            ST_SLEEP: begin
                w_ph_nxt = PH_ZERO;
                if (w_pend) begin
                    if (w_gie) begin
                        w_latch_pc  = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_SLEEP;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ph_nxt    = PH_ZERO;
            end
        endcase
    end

    // State, slot counter and outputs registered from the next-state decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ph         <= PH_ZERO;
            r_push_data  <= {PC_WIDTH{1'b0}};
            r_in_isr     <= 1'b0;
            r_core_stall <= 1'b0;
            r_flush      <= 1'b0;
            r_push       <= 1'b0;
            r_vector     <= 1'b0;
            r_asleep     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ph         <= w_ph_nxt;
            r_in_isr     <= w_in_isr_nxt;
            r_core_stall <= (w_state_nxt != ST_IDLE);
            r_flush      <= (w_state_nxt == ST_FLUSH);
            r_push       <= (w_state_nxt == ST_VECTOR) && (w_ph_nxt == PH_ZERO);
            r_vector     <= (w_state_nxt == ST_VECTOR) && (w_ph_nxt == PH_ONE);
            r_asleep     <= (w_state_nxt == ST_SLEEP);
            if (w_latch_pc) begin
                r_push_data <= bus.pc_in;
            end else begin
                r_push_data <= r_push_data;
            end
        end
    end

    assign bus.core_stall      = r_core_stall;
    assign bus.instr_flush_req = r_flush;
    assign bus.stack_push      = r_push;
    assign bus.stack_push_data = r_push_data;
    assign bus.pc_vector_en    = r_vector;
    assign bus.gie_clr         = r_vector;
    assign bus.pc_vector_addr  = VECTOR_ADDR;
    assign bus.in_isr          = r_in_isr;
    assign bus.asleep          = r_asleep;
    // RETFIE sets GIE in the cycle it executes so the INTCON write lands at the edge
    assign bus.gie_set         = bus.retfie_exec && (r_state != ST_SLEEP) && !rst;

endmodule

// File: doc/interrupt_sequencer.md
# interrupt_sequencer

Controls interrupt entry and SLEEP wake-up for the midrange core. At each instruction boundary it evaluates INTCON/PIR1/PIE1. When an enabled interrupt is pending, it injects a forced-NOP instruction slot and then a vectoring slot. The vectoring slot pushes the return PC, loads the vector address and clears GIE. The block sits beside `instruction_decoder` and drives the program counter, the stack and the program-memory flush.

## Interface
Parameters:
- `PC_WIDTH`, 13, program counter width
- `VECTOR_ADDR`, 13'h0004, interrupt vector
- `SLOT_CYCLES`, 4, clock cycles per instruction slot (power of two, ≥4)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - `clk`  in  1  core clock
  - `rst`  in  1  asynchronous active-high reset
- Inputs:
  - `instr_boundary`  in  1  one-cycle pulse in the last cycle of a completed instruction
  - `intcon`  in  8  INTCON: GIE[7] PEIE[6] T0IE[5] INTE[4] RBIE[3] T0IF[2] INTF[1] RBIF[0]
  - `pir1`  in  8  peripheral flags
  - `pie1`  in  8  peripheral enables
  - `pc_in`  in  PC_WIDTH  current PC (already the return address at boundary)
  - `retfie_exec`  in  1  pulse while RETFIE executes
  - `sleep_exec`  in  1  pulse while SLEEP executes
- Outputs:
  - `core_stall`  out  1  freezes decoder/PC sequencing
  - `instr_flush_req`  out  1  forces NOP into instruction register
  - `stack_push`  out  1  push `stack_push_data`
  - `stack_push_data`  out  PC_WIDTH  latched return address
  - `pc_vector_en`  out  1  load PC with `VECTOR_ADDR`
  - `pc_vector_addr`  out  PC_WIDTH  constant `VECTOR_ADDR`
  - `gie_clr`  out  1  clear INTCON.GIE
  - `gie_set`  out  1  set INTCON.GIE
  - `in_isr`  out  1  high from vector entry until RETFIE
  - `asleep`  out  1  core in SLEEP

## Operation
- The request terms are combinational:
  - `periph` = |(pir1 & pie1)
  - `pend` = (T0IE&T0IF) | (INTE&INTF) | (RBIE&RBIF) | (PEIE&periph)
  - `irq` = GIE & pend
- States: IDLE, FLUSH, VECTOR, SLEEP. Slot position is a log2(SLOT_CYCLES)-bit counter `ph`, cleared on entry to each state.
- IDLE:
  - on `instr_boundary` & `irq`: latch `stack_push_data`←`pc_in`, go to FLUSH.
  - else on `sleep_exec`: go to SLEEP.
  - `retfie_exec` (any state except SLEEP): `gie_set`=1 that cycle, `in_isr`←0.
- FLUSH: `core_stall`=1 and `instr_flush_req`=1 for all SLOT_CYCLES cycles; at ph=SLOT_CYCLES-1 go to VECTOR.
- VECTOR: `core_stall`=1 for all cycles.
  - ph=0: `stack_push`=1.
  - ph=1: `pc_vector_en`=1 and `gie_clr`=1.
  - ph=SLOT_CYCLES-1: `in_isr`←1, go to IDLE.
- SLEEP: `asleep`=1 and `core_stall`=1. Wake on `pend` (GIE ignored). On wake:
  - if GIE=1: latch `pc_in`, go to FLUSH.
  - if GIE=0: go to IDLE; execution continues at the next instruction.
- Output pulses are single-cycle. `pc_vector_addr` is always `VECTOR_ADDR`.

## Timing
- Reset value of every output is 0, and state is IDLE. Reset mid-sequence aborts it: no push or vector is emitted after `rst` rises.
- Latency from boundary pulse to the first flush cycle is 1 cycle (registered). Interrupt entry costs 2×SLOT_CYCLES cycles. `stack_push` occurs SLOT_CYCLES+1 cycles after the boundary.
- `irq` is sampled only on the `instr_boundary` cycle. A flag raised mid-instruction waits for the next boundary.
- Same-boundary `retfie_exec` and `irq` use the sampled (pre-set) GIE=0, so there is no entry. Entry occurs at the next boundary.
- Same-boundary `sleep_exec` and `irq`: the interrupt wins, and SLEEP is not entered.
- `gie_clr` has priority over any software INTCON write in the same cycle; the INTCON register implements that priority.
- `instr_boundary`, `retfie_exec` and `sleep_exec` are ignored outside IDLE, except that `retfie_exec` is also honoured in FLUSH/VECTOR.
- Wake from SLEEP is detected 1 cycle after `pend` rises.

## Structure
- INTCON bit indices (GIE..RBIF) go in the shared `memory_map.vh` as localparams. State encodings go in the same header.
- One sub-module is natural: `irq_pending_logic` (combinational `pend`/`irq` from intcon/pir1/pie1), reused by the future wake/WDT logic.

## Test plan
- **Basic entry.** intcon=8'hA4 (GIE, T0IE, T0IF), pc_in=13'h0123, boundary pulse → FLUSH 4 cycles; `stack_push` with 13'h0123; `pc_vector_en` with 13'h0004; `gie_clr`; `in_isr`=1 after 8 cycles.
- **Peripheral masking.** intcon=8'h80, pir1=8'h01, pie1=8'h01 → no entry. Then intcon=8'hC0 → entry at the next boundary.
- **RETFIE race.** Boundary with `retfie_exec` and a pending flag, GIE=0 → `gie_set` pulse, no flush. Next boundary with GIE=1 → entry.
- **SLEEP wake.** `sleep_exec`, then INTF rises with GIE=0, INTE=1 → `asleep` falls after 1 cycle, state IDLE, no vector. Repeat with GIE=1 → FLUSH then VECTOR.
- **Reset abort.** `rst` asserted at VECTOR ph=0 → all outputs 0 immediately, no `pc_vector_en`. After release, state is IDLE.
- **Stall.** Boundary with `irq` during FLUSH/VECTOR → ignored; exactly one `stack_push` per entry.
